// File: rtl/adex_pkg.sv
// Shared definitions for the AdEx time-multiplexed neuron scheduler:
// fixed-point width, reset value, FSM encoding and event record sizing.
package adex_pkg;

  // Q4.12 signed state variables (membrane potential V and adaptation w).
  localparam int Q_W = 16;

  // Default membrane potential after reset (Q4.12, negative resting level).
  localparam logic [Q_W-1:0] V_INIT_DEFAULT = 16'hF900;

  // Width of the step timestamp carried in every spike event.
  localparam int EVT_TIME_W = 8;

  // Scheduler FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } adex_state_t;

  // Event record = {neuron index, step timestamp}.
  function automatic int evt_width(input int n_neur);
    return $clog2(n_neur) + EVT_TIME_W;
  endfunction

endpackage

// File: rtl/adex_evt_fifo.sv
// Spike-event FIFO (first-word fall-through). A push while full is accepted
// only when a pop happens on the same edge; otherwise the push is discarded
// and the caller decides how to flag it.
module adex_evt_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             do_push, do_pop;

  assign empty    = (count_reg == '0);
  assign full     = (count_reg == (PTR_W+1)'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr_reg];

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/adex_tdm_scheduler.sv
// Time-multiplexed AdEx neuron scheduler. On each enabled tick it walks all
// N_NEUR virtual neurons, sends each neuron's V/w to a shared update core,
// writes the result back and queues spike events {idx, step}.
// Optional feature macro: ADEX_REFRACT_EN (per-neuron refractory skip).
module adex_tdm_scheduler
  import adex_pkg::*;
#(
  parameter int             N_NEUR        = 8,
  parameter int             FIFO_DEPTH    = 4,
  parameter int             REFRACT_STEPS = 3,
  parameter logic [Q_W-1:0] V_INIT        = V_INIT_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      tick,
  input  logic                      init_we,
  input  logic [$clog2(N_NEUR)-1:0] init_idx,
  input  logic [Q_W-1:0]            init_v,
  input  logic [Q_W-1:0]            init_w,
  output logic                      core_req_valid,
  input  logic                      core_req_ready,
  output logic [$clog2(N_NEUR)-1:0] core_req_idx,
  output logic [Q_W-1:0]            core_req_v,
  output logic [Q_W-1:0]            core_req_w,
  input  logic                      core_rsp_valid,
  input  logic [Q_W-1:0]            core_rsp_v,
  input  logic [Q_W-1:0]            core_rsp_w,
  input  logic                      core_rsp_spike,
  output logic                      evt_valid,
  input  logic                      evt_ready,
  output logic [$clog2(N_NEUR)-1:0] evt_idx,
  output logic [EVT_TIME_W-1:0]     evt_time,
  output logic                      busy,
  output logic                      overrun,
  output logic                      evt_drop
);

  localparam int IDX_W = $clog2(N_NEUR);
  localparam int EVT_W = evt_width(N_NEUR);

  // Reject unsupported configurations at elaboration time.
  if (N_NEUR < 2 || N_NEUR > 16 || FIFO_DEPTH < 2 || REFRACT_STEPS < 0) begin : g_param_check
    $error("adex_tdm_scheduler: unsupported parameter set");
  end

  adex_state_t             state_reg, state_next;
  logic [IDX_W-1:0]        idx_reg, idx_next;
  logic [EVT_TIME_W-1:0]   step_cnt_reg, step_cnt_next;
  logic [Q_W-1:0]          v_mem [N_NEUR];
  logic [Q_W-1:0]          w_mem [N_NEUR];
  logic                    overrun_reg, evt_drop_reg;

  logic                    wb_en;      // response accepted this cycle
  logic                    advance;    // current neuron finished (written back or skipped)
  logic                    skip;       // current neuron is refractory
  logic                    last;
  logic                    init_ok;
  logic                    evt_push, evt_pop, fifo_empty, fifo_full;
  logic [EVT_W-1:0]        fifo_out;

  assign last    = (idx_reg == IDX_W'(N_NEUR - 1));
  assign init_ok = init_we && (state_reg == ST_IDLE);
  assign busy    = (state_reg != ST_IDLE);

`ifdef ADEX_REFRACT_EN
  localparam int RC_W = (REFRACT_STEPS < 2) ? 1 : $clog2(REFRACT_STEPS + 1);
  logic [RC_W-1:0] refr_reg [N_NEUR];

  assign skip = (refr_reg[idx_reg] != '0);

  // Refractory counters: count down on each skipped visit, reload on spike.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_NEUR; i++) refr_reg[i] <= '0;
    end else if (state_reg == ST_ISSUE && skip) begin
      refr_reg[idx_reg] <= refr_reg[idx_reg] - 1'b1;
    end else if (wb_en && core_rsp_spike) begin
      refr_reg[idx_reg] <= RC_W'(REFRACT_STEPS);
    end
  end
`else
  assign skip = 1'b0;
`endif

  // FSM state register plus neuron index and step counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      idx_reg      <= '0;
      step_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      step_cnt_reg <= step_cnt_next;
    end
  end

  // Next-state logic; the request is held steady in ISSUE until accepted.
  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    step_cnt_next  = step_cnt_reg;
    core_req_valid = 1'b0;
    wb_en          = 1'b0;
    advance        = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (tick && enable) begin
          state_next = ST_ISSUE;
          idx_next   = '0;
        end
      end
      ST_ISSUE: begin
        if (skip) begin
          advance = 1'b1;
        end else begin
          core_req_valid = 1'b1;
          if (core_req_ready) state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (core_rsp_valid) begin
          wb_en   = 1'b1;
          advance = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (advance) begin
      if (last) begin
        state_next    = ST_IDLE;
        step_cnt_next = step_cnt_reg + 1'b1;
      end else begin
        state_next = ST_ISSUE;
        idx_next   = idx_reg + 1'b1;
      end
    end
  end

  // Neuron state store: host init in IDLE, core writeback in WAIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_NEUR; i++) begin
        v_mem[i] <= V_INIT;
        w_mem[i] <= '0;
      end
    end else if (init_ok) begin
      v_mem[init_idx] <= init_v;
      w_mem[init_idx] <= init_w;
    end else if (wb_en) begin
      v_mem[idx_reg] <= core_rsp_v;
      w_mem[idx_reg] <= core_rsp_w;
    end
  end

  assign core_req_idx = idx_reg;
  assign core_req_v   = v_mem[idx_reg];
  assign core_req_w   = w_mem[idx_reg];

  assign evt_push  = wb_en && core_rsp_spike;
  assign evt_pop   = evt_valid && evt_ready;
  assign evt_valid = !fifo_empty;
  assign evt_idx   = fifo_out[EVT_W-1:EVT_TIME_W];
  assign evt_time  = fifo_out[EVT_TIME_W-1:0];

  adex_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EVT_W)
  ) u_evt_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (evt_push),
    .push_data ({idx_reg, step_cnt_reg}),
    .pop       (evt_ready),
    .pop_data  (fifo_out),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // Sticky error flags: tick while busy, event lost to a full FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun_reg  <= 1'b0;
      evt_drop_reg <= 1'b0;
    end else begin
      if (tick && busy)                      overrun_reg  <= 1'b1;
      if (evt_push && fifo_full && !evt_pop) evt_drop_reg <= 1'b1;
    end
  end

  assign overrun  = overrun_reg;
  assign evt_drop = evt_drop_reg;

endmodule

// File: tb/tb_adex_tdm_scheduler.sv
// Directed bench for adex_tdm_scheduler with a behavioural core that echoes
// V+1 / w+2 one cycle after each accepted request.
module tb_adex_tdm_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic        tick = 1'b0;
  logic        init_we = 1'b0;
  logic [2:0]  init_idx = '0;
  logic [15:0] init_v = '0;
  logic [15:0] init_w = '0;
  logic        core_req_valid;
  logic        core_req_ready = 1'b1;
  logic [2:0]  core_req_idx;
  logic [15:0] core_req_v, core_req_w;
  logic        core_rsp_valid = 1'b0;
  logic [15:0] core_rsp_v = '0;
  logic [15:0] core_rsp_w = '0;
  logic        core_rsp_spike = 1'b0;
  logic        evt_valid;
  logic        evt_ready = 1'b0;
  logic [2:0]  evt_idx;
  logic [7:0]  evt_time;
  logic        busy, overrun, evt_drop;

  int n_checks = 0;
  int n_errors = 0;

  // written by the main sequence, read by the core model
  logic [7:0]  spike_mask = '0;
  int          stall_gen = 0;
  int          stall_len = 0;
  logic [2:0]  stall_idx = '0;
  int          stray_gen = 0;

  // written by the core model only
  logic [2:0]  log_idx [256];
  logic [15:0] log_v   [256];
  logic [15:0] log_w   [256];
  int          log_n = 0;

  always #5 clk = ~clk;

  adex_tdm_scheduler dut (
    .clk(clk), .reset(reset), .enable(enable), .tick(tick),
    .init_we(init_we), .init_idx(init_idx), .init_v(init_v), .init_w(init_w),
    .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
    .core_req_idx(core_req_idx), .core_req_v(core_req_v), .core_req_w(core_req_w),
    .core_rsp_valid(core_rsp_valid), .core_rsp_v(core_rsp_v), .core_rsp_w(core_rsp_w),
    .core_rsp_spike(core_rsp_spike),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_idx(evt_idx), .evt_time(evt_time),
    .busy(busy), .overrun(overrun), .evt_drop(evt_drop)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Core model: drives at negedges, one response per accepted request.
  initial begin : core_model
    logic        pend = 1'b0;
    logic [2:0]  pend_idx = '0;
    logic [15:0] pend_v = '0, pend_w = '0;
    logic        in_stall = 1'b0;
    int          stall_done = 0, stall_left = 0, stray_done = 0;
    logic [2:0]  st_idx = '0;
    logic [15:0] st_v = '0, st_w = '0;
    forever begin
      @(negedge clk);
      core_rsp_valid = 1'b0;
      core_rsp_spike = 1'b0;
      if (pend) begin
        core_rsp_valid = 1'b1;
        core_rsp_v     = pend_v + 16'd1;
        core_rsp_w     = pend_w + 16'd2;
        core_rsp_spike = spike_mask[pend_idx];
        pend = 1'b0;
      end else if (stray_gen != stray_done) begin
        stray_done     = stray_gen;
        core_rsp_valid = 1'b1;
        core_rsp_v     = 16'hDEAD;
        core_rsp_w     = 16'hBEEF;
        core_rsp_spike = 1'b1;
      end
      core_req_ready = 1'b1;
      if (in_stall) begin
        check_eq("stall_valid", {31'd0, core_req_valid}, 32'd1);
        check_eq("stall_idx", {29'd0, core_req_idx}, {29'd0, st_idx});
        check_eq("stall_v", {16'd0, core_req_v}, {16'd0, st_v});
        check_eq("stall_w", {16'd0, core_req_w}, {16'd0, st_w});
        if (stall_left > 0) begin
          core_req_ready = 1'b0;
          stall_left--;
        end else begin
          in_stall = 1'b0;
        end
      end else if (core_req_valid && stall_done != stall_gen && core_req_idx == stall_idx) begin
        stall_done     = stall_gen;
        in_stall       = 1'b1;
        st_idx         = core_req_idx;
        st_v           = core_req_v;
        st_w           = core_req_w;
        core_req_ready = 1'b0;
        stall_left     = stall_len - 1;
      end
      if (core_req_valid && core_req_ready) begin
        if (log_n < 256) begin
          log_idx[log_n] = core_req_idx;
          log_v[log_n]   = core_req_v;
          log_w[log_n]   = core_req_w;
        end
        log_n++;
        pend     = 1'b1;
        pend_idx = core_req_idx;
        pend_v   = core_req_v;
        pend_w   = core_req_w;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulse_tick();
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy && cyc < 400) begin
      cyc++;
      @(negedge clk);
    end
    if (busy) check_eq("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic run_step(output int cyc, output int base);
    base = log_n;
    pulse_tick();
    wait_idle(cyc);
    $display("step: %0d requests in %0d cycles", log_n - base, cyc);
  endtask

  // Verify a full step issued idx 0..7 with uniform expected V/w.
  task automatic check_uniform(input string tag, input int base, input logic [15:0] ev,
                               input logic [15:0] ew);
    check_eq({tag, "_count"}, log_n - base, 32'd8);
    for (int i = 0; i < 8; i++) begin
      check_eq({tag, "_idx"}, {29'd0, log_idx[base+i]}, i);
      check_eq({tag, "_v"}, {16'd0, log_v[base+i]}, {16'd0, ev});
      check_eq({tag, "_w"}, {16'd0, log_w[base+i]}, {16'd0, ew});
    end
  endtask

  task automatic pop_check(input logic [2:0] eidx, input logic [7:0] etime);
    check_eq("evt_valid", {31'd0, evt_valid}, 32'd1);
    check_eq("evt_idx", {29'd0, evt_idx}, {29'd0, eidx});
    check_eq("evt_time", {24'd0, evt_time}, {24'd0, etime});
    $display("pop: idx=%0d time=%0d", evt_idx, evt_time);
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
  endtask

  initial begin : main
    int cyc, base, cnt;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // reset state
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_req_valid", {31'd0, core_req_valid}, 32'd0);
    check_eq("rst_evt_valid", {31'd0, evt_valid}, 32'd0);
    check_eq("rst_overrun", {31'd0, overrun}, 32'd0);
    check_eq("rst_evt_drop", {31'd0, evt_drop}, 32'd0);

    // tick with enable low is ignored
    enable = 1'b0;
    pulse_tick();
    repeat (3) @(negedge clk);
    check_eq("dis_busy", {31'd0, busy}, 32'd0);
    check_eq("dis_reqs", log_n, 32'd0);
    enable = 1'b1;

    // stray response while IDLE is ignored
    stray_gen++;
    repeat (3) @(negedge clk);
    check_eq("stray_evt", {31'd0, evt_valid}, 32'd0);

    // step 0: 8 requests with reset V, minimum latency 16 cycles
    run_step(cyc, base);
    check_eq("s0_cycles", cyc, 32'd16);
    check_uniform("s0", base, 16'hF900, 16'h0000);

    // step 1: stall neuron 3 for 5 cycles
    stall_idx = 3'd3;
    stall_len = 5;
    stall_gen++;
    run_step(cyc, base);
    check_eq("s1_cycles", cyc, 32'd21);
    check_uniform("s1", base, 16'hF901, 16'h0002);

    // spikes on 2 and 5, read back in order
    do_reset();
    spike_mask = 8'h24;
    run_step(cyc, base);
    check_uniform("sp", base, 16'hF900, 16'h0000);
    pop_check(3'd2, 8'd0);
    pop_check(3'd5, 8'd0);
    check_eq("sp_empty", {31'd0, evt_valid}, 32'd0);
    check_eq("sp_nodrop", {31'd0, evt_drop}, 32'd0);

    // push and pop on the same edge while full: both succeed
    do_reset();
    spike_mask = 8'h1F;
    base = log_n;
    pulse_tick();
    cnt = 0;
    while (!(busy && !core_req_valid && core_req_idx == 3'd4) && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 100) check_eq("pp_sync", {29'd0, busy, !core_req_valid, core_req_idx == 3'd4}, 32'd7);
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
    wait_idle(cyc);
    check_eq("pp_nodrop", {31'd0, evt_drop}, 32'd0);
    for (int i = 1; i <= 4; i++) pop_check(3'(i), 8'd0);
    check_eq("pp_empty", {31'd0, evt_valid}, 32'd0);

    // six spikes into a depth-4 FIFO: four kept, drop flagged
    do_reset();
    spike_mask = 8'h3F;
    run_step(cyc, base);
    check_eq("drop_flag", {31'd0, evt_drop}, 32'd1);
    for (int i = 0; i < 4; i++) pop_check(3'(i), 8'd0);
    check_eq("drop_empty", {31'd0, evt_valid}, 32'd0);
    spike_mask = 8'h00;

    // second tick while busy: overrun, single step only
    do_reset();
    base = log_n;
    pulse_tick();
    repeat (2) @(negedge clk);
    pulse_tick();
    wait_idle(cyc);
    repeat (6) @(negedge clk);
    check_eq("ovr_flag", {31'd0, overrun}, 32'd1);
    check_eq("ovr_reqs", log_n - base, 32'd8);
    check_eq("ovr_idle", {31'd0, busy}, 32'd0);
    do_reset();
    check_eq("ovr_cleared", {31'd0, overrun}, 32'd0);

    // host init together with tick lands first; init while busy ignored
    @(negedge clk);
    base = log_n;
    init_we = 1'b1; init_idx = 3'd0; init_v = 16'h1234; init_w = 16'h0055;
    tick = 1'b1;
    @(negedge clk);
    init_we = 1'b0; tick = 1'b0;
    repeat (4) @(negedge clk);
    init_we = 1'b1; init_idx = 3'd6; init_v = 16'h7777; init_w = 16'h7777;
    @(negedge clk);
    init_we = 1'b0;
    wait_idle(cyc);
    check_eq("init_v0", {16'd0, log_v[base]}, 32'h1234);
    check_eq("init_w0", {16'd0, log_w[base]}, 32'h0055);
    check_eq("init_v6", {16'd0, log_v[base+6]}, 32'h0000F900);
    run_step(cyc, base);
    check_eq("init2_v0", {16'd0, log_v[base]}, 32'h1235);
    check_eq("init2_w0", {16'd0, log_w[base]}, 32'h0057);
    check_eq("init2_v6", {16'd0, log_v[base+6]}, 32'h0000F901);
    check_eq("init2_w6", {16'd0, log_w[base+6]}, 32'h0002);

    // reset mid-step abandons the request and ignores its response
    pulse_tick();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("mid_busy", {31'd0, busy}, 32'd0);
    check_eq("mid_req_valid", {31'd0, core_req_valid}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    run_step(cyc, base);
    check_uniform("mid", base, 16'hF900, 16'h0000);

`ifdef ADEX_REFRACT_EN
    // refractory skip: neuron 1 spikes in step 0, rests for steps 1..3
    do_reset();
    spike_mask = 8'h02;
    run_step(cyc, base);
    spike_mask = 8'h00;
    for (int s = 1; s <= 4; s++) begin
      run_step(cyc, base);
      cnt = 0;
      for (int i = base; i < log_n; i++) if (log_idx[i] == 3'd1) cnt++;
      check_eq("refr_idx1", cnt, (s == 4) ? 32'd1 : 32'd0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
